// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: one command in, one single-beat read or write on the bus,
// one response out. A watchdog aborts transactions to a slave that never answers.
module axil_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [63:0] cmd_wdata,
    input  logic [7:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic        busy,

    output logic [31:0] axil_awaddr,
    output logic [2:0]  axil_awprot,
    output logic        axil_awvalid,
    input  logic        axil_awready,
    output logic [63:0] axil_wdata,
    output logic [7:0]  axil_wstrb,
    output logic        axil_wvalid,
    input  logic        axil_wready,
    input  logic [1:0]  axil_bresp,
    input  logic        axil_bvalid,
    output logic        axil_bready,
    output logic [31:0] axil_araddr,
    output logic [2:0]  axil_arprot,
    output logic        axil_arvalid,
    input  logic        axil_arready,
    input  logic [63:0] axil_rdata,
    input  logic [1:0]  axil_rresp,
    input  logic        axil_rvalid,
    output logic        axil_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    localparam bit          WDOG_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [32:0] WDOG_LIMIT  = 33'(TIMEOUT_CYCLES);

    state_t      state_reg, state_next;
    logic        aw_done_reg, aw_done_next;
    logic        w_done_reg, w_done_next;
    logic [31:0] wd_cnt_reg, wd_cnt_next;
    logic [63:0] rdata_reg, rdata_next;
    logic [1:0]  resp_reg, resp_next;
    logic        timeout_reg, timeout_next;

    logic [31:0] addr_reg;
    logic [63:0] wdata_reg;
    logic [7:0]  wstrb_reg;

    logic        accept;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        expire;

    // Every bus output is decoded from registered state only, so no AXI input
    // can reach an AXI output combinationally.
    assign cmd_ready    = (state_reg == IDLE);
    assign busy         = (state_reg != IDLE);
    assign rsp_valid    = (state_reg == RSP);
    assign rsp_rdata    = rdata_reg;
    assign rsp_resp     = resp_reg;
    assign rsp_timeout  = timeout_reg;

    assign axil_awaddr  = addr_reg;
    assign axil_araddr  = addr_reg;
    assign axil_awprot  = 3'b000;
    assign axil_arprot  = 3'b000;
    assign axil_wdata   = wdata_reg;
    assign axil_wstrb   = wstrb_reg;
    assign axil_awvalid = (state_reg == WR_REQ) && !aw_done_reg;
    assign axil_wvalid  = (state_reg == WR_REQ) && !w_done_reg;
    assign axil_bready  = (state_reg == WR_RESP);
    assign axil_arvalid = (state_reg == RD_REQ);
    assign axil_rready  = (state_reg == RD_RESP);

    assign accept = cmd_valid && cmd_ready;
    assign aw_hs  = axil_awvalid && axil_awready;
    assign w_hs   = axil_wvalid && axil_wready;
    assign b_hs   = axil_bvalid && axil_bready;
    assign ar_hs  = axil_arvalid && axil_arready;
    assign r_hs   = axil_rvalid && axil_rready;

    // The counter reaches the limit on the edge closing this cycle; a state
    // advance on that same edge takes priority over the abort.
    assign expire = WDOG_EN && (({1'b0, wd_cnt_reg} + 33'd1) >= WDOG_LIMIT);

    always_comb begin
        state_next   = state_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        wd_cnt_next  = wd_cnt_reg;
        rdata_next   = rdata_reg;
        resp_next    = resp_reg;
        timeout_next = timeout_reg;

        if (state_reg inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP} && wd_cnt_reg != '1) begin
            wd_cnt_next = wd_cnt_reg + 32'd1;
        end

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    state_next   = cmd_write ? WR_REQ : RD_REQ;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    wd_cnt_next  = '0;
                end
            end
            WR_REQ: begin
                if (aw_hs) aw_done_next = 1'b1;
                if (w_hs)  w_done_next  = 1'b1;
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    state_next = WR_RESP;
                end else if (expire) begin
                    state_next = RSP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_next = RSP;
                end else if (expire) begin
                    state_next = RSP;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_next = RD_RESP;
                end else if (expire) begin
                    state_next = RSP;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    state_next = RSP;
                end else if (expire) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Response fields: write completion, read completion, or watchdog abort.
        if (state_reg == WR_RESP && b_hs) begin
            resp_next    = axil_bresp;
            rdata_next   = '0;
            timeout_next = 1'b0;
        end else if (state_reg == RD_RESP && r_hs) begin
            resp_next    = axil_rresp;
            rdata_next   = axil_rdata;
            timeout_next = 1'b0;
        end else if (state_reg inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}
                     && state_next == RSP) begin
            resp_next    = 2'b11;
            rdata_next   = '0;
            timeout_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            wd_cnt_reg  <= '0;
            rdata_reg   <= '0;
            resp_reg    <= 2'b00;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            wd_cnt_reg  <= wd_cnt_next;
            rdata_reg   <= rdata_next;
            resp_reg    <= resp_next;
            timeout_reg <= timeout_next;
        end
    end

    // Command payload is only observed while a transaction is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_reg  <= cmd_addr;
            wdata_reg <= cmd_wdata;
            wstrb_reg <= cmd_wstrb;
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a small configurable AXI4-Lite slave.
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axil_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .axil_awaddr(awaddr), .axil_awprot(awprot), .axil_awvalid(awvalid),
        .axil_awready(awready), .axil_wdata(wdata), .axil_wstrb(wstrb),
        .axil_wvalid(wvalid), .axil_wready(wready), .axil_bresp(bresp),
        .axil_bvalid(bvalid), .axil_bready(bready), .axil_araddr(araddr),
        .axil_arprot(arprot), .axil_arvalid(arvalid), .axil_arready(arready),
        .axil_rdata(rdata), .axil_rresp(rresp), .axil_rvalid(rvalid),
        .axil_rready(rready)
    );

    always #5 clk = ~clk;

    // Slave knobs, set from the stimulus block.
    int          aw_lat = 0, w_lat = 0, ar_lat = 0;
    logic        ar_never = 1'b0, b_hold = 1'b0;
    logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
    logic [63:0] rdata_val = '0;

    int   aw_wait, w_wait, ar_wait;
    logic aw_seen, w_seen, b_pend, r_pend;
    logic aw_got, w_got;

    assign awready = awvalid && (aw_wait >= aw_lat);
    assign wready  = wvalid && (w_wait >= w_lat);
    assign arready = arvalid && !ar_never && (ar_wait >= ar_lat);
    assign bvalid  = b_pend && !b_hold;
    assign bresp   = bresp_val;
    assign rvalid  = r_pend;
    assign rdata   = rdata_val;
    assign rresp   = rresp_val;
    assign aw_got  = aw_seen || (awvalid && awready);
    assign w_got   = w_seen || (wvalid && wready);

    always @(posedge clk) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            if (bvalid && bready) b_pend <= 1'b0;
            if (aw_got && w_got && !b_pend) begin
                b_pend <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
            end else begin
                aw_seen <= aw_got; w_seen <= w_got;
            end
            if (rvalid && rready) r_pend <= 1'b0;
            if (arvalid && arready) r_pend <= 1'b1;
        end
    end

    // Bus monitor: handshake counts, cycle stamps and protocol-rule violations.
    int cyc = 0, acc_cyc = 0, acc_cnt = 0, rsp_hs_cyc = 0, rsp_hi = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int aw_cyc = 0, w_cyc = 0, b_cyc = 0, ar_hi = 0;
    int aw_err = 0, w_err = 0, w_stab_err = 0, rr_err = 0;
    logic [31:0] awaddr_cap = '0, araddr_cap = '0;
    logic [63:0] wdata_cap = '0, wdata_d = '0;
    logic [7:0]  wstrb_cap = '0;
    logic        aw_hs_d = 1'b0, w_hs_d = 1'b0, w_wait_d = 1'b0, rsp_valid_d = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            acc_cyc <= cyc; acc_cnt <= acc_cnt + 1;
        end
        if ((awvalid && awready) === 1'b1) begin
            aw_cnt <= aw_cnt + 1; aw_cyc <= cyc; awaddr_cap <= awaddr;
        end
        if ((wvalid && wready) === 1'b1) begin
            w_cnt <= w_cnt + 1; w_cyc <= cyc; wdata_cap <= wdata; wstrb_cap <= wstrb;
        end
        if ((bvalid && bready) === 1'b1) begin
            b_cnt <= b_cnt + 1; b_cyc <= cyc;
        end
        if ((arvalid && arready) === 1'b1) begin
            ar_cnt <= ar_cnt + 1; araddr_cap <= araddr;
        end
        if ((rvalid && rready) === 1'b1) r_cnt <= r_cnt + 1;
        if ((rsp_valid && rsp_ready) === 1'b1) rsp_hs_cyc <= cyc;
        if (arvalid === 1'b1) ar_hi <= ar_hi + 1;
        if (rsp_valid === 1'b1 && !rsp_valid_d) rsp_hi <= rsp_hi + 1;
        if (aw_hs_d && awvalid === 1'b1) aw_err <= aw_err + 1;
        if (w_hs_d && wvalid === 1'b1) w_err <= w_err + 1;
        if (w_wait_d && wvalid === 1'b1 && wdata !== wdata_d) w_stab_err <= w_stab_err + 1;
        if (rvalid === 1'b1 && rready !== 1'b1) rr_err <= rr_err + 1;
        aw_hs_d     <= ((awvalid && awready) === 1'b1);
        w_hs_d      <= ((wvalid && wready) === 1'b1);
        w_wait_d    <= ((wvalid && !wready) === 1'b1);
        wdata_d     <= wdata;
        rsp_valid_d <= (rsp_valid === 1'b1);
    end

    int n_vec = 0, n_err = 0;
    int lat;
    logic [63:0] got_rdata;
    logic [1:0]  got_resp;
    logic        got_to;
    int          snap_a, snap_b, snap_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [63:0] d,
                         input logic [7:0] s);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        for (int i = 0; i < 100 && cmd_ready !== 1'b1; i++) @(negedge clk);
        if (cmd_ready !== 1'b1) chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 100 && rsp_valid !== 1'b1; i++) @(negedge clk);
        chk("rsp_valid_wait", {63'd0, rsp_valid}, 64'd1);
        lat       = cyc - acc_cyc;
        got_rdata = rsp_rdata;
        got_resp  = rsp_resp;
        got_to    = rsp_timeout;
        $display("txn %s addr=0x%08h lat=%0d rdata=0x%016h resp=%0d timeout=%0d",
                 cmd_write ? "WR" : "RD", cmd_addr, lat, got_rdata, got_resp, got_to);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state: {cmd_ready,busy,awvalid,wvalid,arvalid,bready,rready,rsp_valid,rsp_timeout}
        chk("reset_ctrl", {55'd0, cmd_ready, busy, awvalid, wvalid, arvalid, bready,
                           rready, rsp_valid, rsp_timeout}, 64'h100);
        chk("reset_rdata", rsp_rdata, 64'd0);
        chk("reset_resp", {62'd0, rsp_resp}, 64'd0);
        chk("reset_prot", {58'd0, awprot, arprot}, 64'd0);

        // Zero-wait write to 0x20.
        issue(1'b1, 32'h20, 64'h0000_0010_0000_0030, 8'hFF);
        wait_rsp();
        chk("wr0_rsp_lat", lat, 3);
        chk("wr0_fields", {got_rdata, got_resp, got_to} == {64'd0, 2'b00, 1'b0}, 1);
        consume();
        chk("wr0_aw_lat", aw_cyc - acc_cyc, 1);
        chk("wr0_w_lat", w_cyc - acc_cyc, 1);
        chk("wr0_b_lat", b_cyc - acc_cyc, 2);
        chk("wr0_counts", {aw_cnt[15:0], w_cnt[15:0], b_cnt[15:0]}, 48'h0001_0001_0001);
        chk("wr0_awaddr", awaddr_cap, 32'h20);
        chk("wr0_wdata", wdata_cap, 64'h0000_0010_0000_0030);
        chk("wr0_wstrb", wstrb_cap, 8'hFF);

        // Read from 0x40, slave registers arready one cycle after arvalid.
        ar_lat = 1; rdata_val = 64'h1234_5678_9ABC_DEF0;
        issue(1'b0, 32'h40, 64'd0, 8'h00);
        wait_rsp();
        chk("rd0_rsp_lat", lat, 4);
        chk("rd0_rdata", got_rdata, 64'h1234_5678_9ABC_DEF0);
        chk("rd0_resp_to", {61'd0, got_resp, got_to}, 0);
        consume();
        chk("rd0_counts", {ar_cnt[15:0], r_cnt[15:0]}, 32'h0001_0001);
        chk("rd0_araddr", araddr_cap, 32'h40);
        chk("rd0_rready", rr_err, 0);
        ar_lat = 0;

        // awready three cycles ahead of wready; slave returns SLVERR.
        w_lat = 3; bresp_val = 2'b10;
        snap_a = b_cnt;
        issue(1'b1, 32'h88, 64'hA5A5_0000_FFFF_1111, 8'h0F);
        wait_rsp();
        chk("wr1_resp", {62'd0, got_resp}, 2'b10);
        consume();
        chk("wr1_aw_w_gap", w_cyc - aw_cyc, 3);
        chk("wr1_aw_drop", aw_err, 0);
        chk("wr1_w_drop", w_err, 0);
        chk("wr1_w_stable", w_stab_err, 0);
        chk("wr1_wdata", wdata_cap, 64'hA5A5_0000_FFFF_1111);
        chk("wr1_b_once", b_cnt - snap_a, 1);
        w_lat = 0; bresp_val = 2'b00;

        // rsp_ready held low for 5 cycles with the next command already waiting.
        rdata_val = 64'hCAFE_F00D_0BAD_BEEF;
        issue(1'b1, 32'h30, 64'h1, 8'h01);
        wait_rsp();
        cmd_write = 1'b0; cmd_addr = 32'h44; cmd_valid = 1'b1;
        snap_a = acc_cnt; snap_b = aw_cnt + w_cnt; snap_c = ar_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_ctrl", {61'd0, rsp_valid, cmd_ready,
                              awvalid | wvalid | arvalid | bready | rready}, 3'b100);
            chk("hold_fields", {rsp_rdata, rsp_resp, rsp_timeout} ==
                               {got_rdata, got_resp, got_to}, 1);
        end
        consume();
        chk("hold_no_accept", acc_cnt - snap_a, 0);
        chk("hold_no_axi", (aw_cnt + w_cnt - snap_b) + (ar_cnt - snap_c), 0);
        issue(1'b0, 32'h44, 64'd0, 8'h00);
        chk("b2b_accept_cyc", acc_cyc - rsp_hs_cyc, 1);
        wait_rsp();
        chk("b2b_rdata", got_rdata, 64'hCAFE_F00D_0BAD_BEEF);
        consume();

        // Watchdog: arready never comes.
        ar_never = 1'b1;
        snap_a = ar_hi; snap_b = ar_cnt;
        issue(1'b0, 32'h50, 64'd0, 8'h00);
        wait_rsp();
        chk("to_lat", lat, 17);
        chk("to_arvalid_low", {63'd0, arvalid}, 0);
        chk("to_arvalid_cycles", ar_hi - snap_a, 16);
        chk("to_fields", {got_rdata, got_resp, got_to} == {64'd0, 2'b11, 1'b1}, 1);
        chk("to_no_ar_hs", ar_cnt - snap_b, 0);
        consume();
        ar_never = 1'b0;
        issue(1'b1, 32'h58, 64'h77, 8'hFF);
        wait_rsp();
        chk("post_to_wr", {lat[7:0], got_resp, got_to}, {8'd3, 2'b00, 1'b0});
        consume();

        // Reset while waiting in WR_RESP.
        b_hold = 1'b1;
        issue(1'b1, 32'h60, 64'h99, 8'hFF);
        for (int i = 0; i < 20 && bready !== 1'b1; i++) @(negedge clk);
        chk("rst_reach_wr_resp", {63'd0, bready}, 1);
        snap_a = rsp_hi;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ctrl", {55'd0, cmd_ready, busy, awvalid, wvalid, arvalid, bready,
                         rready, rsp_valid, rsp_timeout}, 64'h100);
        chk("rst_rsp", {rsp_rdata, rsp_resp} == {64'd0, 2'b00}, 1);
        b_hold = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_no_rsp", rsp_hi - snap_a, 0);
        snap_b = b_cnt;
        issue(1'b1, 32'h68, 64'h1234, 8'h03);
        wait_rsp();
        chk("post_rst_wr", {lat[7:0], got_resp, got_to}, {8'd3, 2'b00, 1'b0});
        consume();
        chk("post_rst_b_once", b_cnt - snap_b, 1);
        chk("post_rst_wdata", wdata_cap, 64'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
